// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcodes, ALU/mux selector codes and the control word carried to the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_ADDI_EXEC = 4'd8,
        ST_ADDI_WB   = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_word_t;

    // An instruction retires on the edge that leaves its final state.
    function automatic logic retires_on_exit(state_t s, logic mem_ready);
        case (s)
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: return 1'b1;
            ST_MEM_WRITE:                                       return mem_ready;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit, the IR opcode field, the datapath controls
// and the shared memory handshake.
interface multicycle_control_unit_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    // Memory handshake: MemRead/MemWrite is the request and stays asserted
    // until a rising clock edge samples mem_ready=1; that edge completes the
    // access. mem_ready has no meaning while no request is asserted.
    logic [5:0]         inscod;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               Memtoreg;
    logic               RegDist;
    logic               Regwrite;
    logic               ALUsrcA;
    logic [1:0]         ALUsrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUop;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  inscod, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Memtoreg, RegDist, Regwrite, ALUsrcA, ALUsrcB, PCSource,
               ALUop, illegal, retired
    );

    modport slave (
        output inscod, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Memtoreg, RegDist, Regwrite, ALUsrcA, ALUsrcB, PCSource,
               ALUop, illegal, retired
    );

endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// Moore output decode: maps the current state to the datapath control word.
// mem_ready only gates the FETCH-side PC/IR loads so the PC cannot run ahead of a stall.
module mcu_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction, stalls on the
// memory handshake, traps on unsupported opcodes and counts retirements.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus,
    output state_t                      state_o
);

    state_t           state_q, state_d;
    logic [5:0]       opcode_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire_now;
    ctrl_word_t       ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.inscod)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default:      state_d = ST_TRAP;
                endcase
            end
            // Only lw/sw reach MEM_ADDR, so the latched opcode picks the direction.
            ST_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WRITE: if (bus.mem_ready) state_d = ST_FETCH;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
    end

    mcu_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    assign retire_now = retires_on_exit(state_q, bus.mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q == ST_DECODE) opcode_q <= bus.inscod;
            if (state_q == ST_DECODE && state_d == ST_TRAP) illegal_q <= 1'b1;
            if (retire_now) retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.Memtoreg    = ctrl.mem_to_reg;
    assign bus.RegDist     = ctrl.reg_dst;
    assign bus.Regwrite    = ctrl.reg_write;
    assign bus.ALUsrcA     = ctrl.alu_src_a;
    assign bus.ALUsrcB     = ctrl.alu_src_b;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUop       = ALUOP_W'(ctrl.alu_op);
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;
    assign state_o         = state_q;

endmodule
